// File: rtl/float_pkg.sv
// Shared single-precision field layout, constants and accumulator state encoding
// for the neuron floating-point datapath.
package float_pkg;

   localparam int FLOAT_W  = 32;
   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [FLOAT_W-1:0] FLOAT_ZERO    = 32'h0000_0000;
   localparam logic [FLOAT_W-1:0] FLOAT_POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } acc_state_t;

   // NaN encodings share exponent 255 and are deliberately folded into infinity.
   function automatic logic is_inf(input logic [FLOAT_W-1:0] f);
      return f[EXP_MSB:EXP_LSB] == 8'hFF;
   endfunction

endpackage

// File: rtl/float_adder.sv
// Combinational single-precision adder: truncating, flush-to-zero, saturating to
// infinity with an overflow flag. Shared with the bias and activation stages.
module float_adder
   import float_pkg::*;
(
   input  logic [FLOAT_W-1:0] i_a,
   input  logic [FLOAT_W-1:0] i_b,
   output logic [FLOAT_W-1:0] o_sum,
   output logic               o_overflow
);

   logic [30:0]       w_key_a;
   logic [30:0]       w_key_b;
   logic [30:0]       w_big_key;
   logic [30:0]       w_small_key;
   logic              w_swap;
   logic              w_big_sign;
   logic              w_small_sign;
   logic [7:0]        w_diff;
   logic [27:0]       w_big_al;
   logic [27:0]       w_small_al;
   logic [27:0]       w_raw;
   logic [27:0]       w_norm;
   logic [4:0]        w_lead;
   logic [4:0]        w_lsh;
   logic signed [9:0] w_exp_n;

   // Denormals collapse to a zero magnitude key so they never contribute.
   assign w_key_a = (i_a[EXP_MSB:EXP_LSB] == 8'd0) ? 31'd0 : i_a[30:0];
   assign w_key_b = (i_b[EXP_MSB:EXP_LSB] == 8'd0) ? 31'd0 : i_b[30:0];
   assign w_swap  = w_key_b > w_key_a;

   // Align, add/subtract, normalise and pack the finite-operand result.
   always_comb begin
      w_big_key    = w_swap ? w_key_b : w_key_a;
      w_small_key  = w_swap ? w_key_a : w_key_b;
      w_big_sign   = w_swap ? i_b[SIGN_BIT] : i_a[SIGN_BIT];
      w_small_sign = w_swap ? i_a[SIGN_BIT] : i_b[SIGN_BIT];
      w_diff       = w_big_key[30:23] - w_small_key[30:23];
      w_big_al     = (w_big_key == 31'd0) ? 28'd0 : {2'b01, w_big_key[22:0], 3'b000};
      w_small_al   = (w_small_key == 31'd0) ? 28'd0 : ({2'b01, w_small_key[22:0], 3'b000} >> w_diff);
      w_raw        = (w_big_sign == w_small_sign) ? (w_big_al + w_small_al) : (w_big_al - w_small_al);
      w_lead       = 5'd0;
      for (int i = 0; i < 28; i++) begin
         w_lead = w_raw[i] ? 5'(i) : w_lead;
      end
      if (w_lead == 5'd27) begin
         w_lsh   = 5'd0;
         w_norm  = w_raw >> 1;
         w_exp_n = $signed({2'b00, w_big_key[30:23]}) + 10'sd1;
      end else begin
         w_lsh   = 5'd26 - w_lead;
         w_norm  = w_raw << w_lsh;
         w_exp_n = $signed({2'b00, w_big_key[30:23]}) - $signed({5'd0, w_lsh});
      end

      o_sum      = FLOAT_ZERO;
      o_overflow = 1'b0;
      if (is_inf(i_a) || is_inf(i_b)) begin
         o_overflow = 1'b1;
         if (is_inf(i_a) && is_inf(i_b) && (i_a[SIGN_BIT] != i_b[SIGN_BIT])) begin
            o_sum = FLOAT_POS_INF;
         end else if (is_inf(i_a)) begin
            o_sum = {i_a[SIGN_BIT], FLOAT_POS_INF[30:0]};
         end else begin
            o_sum = {i_b[SIGN_BIT], FLOAT_POS_INF[30:0]};
         end
      end else if (w_raw == 28'd0) begin
         // Exact cancellation is +0; only -0 + -0 keeps the negative sign.
         o_sum = {w_big_sign & w_small_sign, 31'd0};
      end else if (w_exp_n >= 10'sd255) begin
         o_overflow = 1'b1;
         o_sum      = {w_big_sign, FLOAT_POS_INF[30:0]};
      end else if (w_exp_n <= 10'sd0) begin
         o_sum = {w_big_sign, 31'd0};
      end else begin
         o_sum = {w_big_sign, w_exp_n[7:0], w_norm[25:3]};
      end
   end

endmodule

// File: rtl/float_accumulator.sv
// Streaming accumulator: sums one packet of products plus a bias and holds the
// result on a valid/ready output until the activation stage takes it.
module float_accumulator
   import float_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MAX_TERMS = 256,
   parameter int CNT_W     = 9
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [XLEN-1:0]  i_in_data,
   input  logic             i_in_last,
   input  logic [XLEN-1:0]  i_bias,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [XLEN-1:0]  o_out_data,
   output logic [CNT_W-1:0] o_out_count,
   output logic             o_out_overflow,
   output logic             o_out_forced
);

   acc_state_t       r_state;
   logic [XLEN-1:0]  r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_data;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_overflow;
   logic             r_out_forced;

   logic [XLEN-1:0]  w_add_a;
   logic [XLEN-1:0]  w_sum;
   logic             w_add_ovf;
   logic             w_accept;
   logic             w_close;
   logic             w_next_ovf;
   logic [CNT_W-1:0] w_next_count;

   // The first beat of a packet adds onto the bias instead of the running sum.
   assign w_accept     = i_in_valid & r_in_ready;
   assign w_add_a      = (r_state == ST_IDLE) ? i_bias : r_acc;
   assign w_next_count = (r_state == ST_IDLE) ? CNT_W'(1) : (r_count + CNT_W'(1));
   assign w_next_ovf   = ((r_state == ST_ACCUM) & r_ovf) | w_add_ovf;
   assign w_close      = i_in_last | (w_next_count == CNT_W'(MAX_TERMS));

   float_adder u_adder (
      .i_a        (w_add_a),
      .i_b        (i_in_data),
      .o_sum      (w_sum),
      .o_overflow (w_add_ovf)
   );

   // Packet FSM with registered handshake and result outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= ST_IDLE;
         r_acc          <= FLOAT_ZERO;
         r_count        <= '0;
         r_ovf          <= 1'b0;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_out_data     <= FLOAT_ZERO;
         r_out_count    <= '0;
         r_out_overflow <= 1'b0;
         r_out_forced   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ACCUM: begin
               if (w_accept) begin
                  r_acc   <= w_sum;
                  r_count <= w_next_count;
                  r_ovf   <= w_next_ovf;
                  if (w_close) begin
                     r_state        <= ST_DONE;
                     r_in_ready     <= 1'b0;
                     r_out_valid    <= 1'b1;
                     r_out_data     <= w_sum;
                     r_out_count    <= w_next_count;
                     r_out_overflow <= w_next_ovf;
                     r_out_forced   <= ~i_in_last;
                  end else begin
                     r_state <= ST_ACCUM;
                  end
               end
            end
            ST_DONE: begin
               if (i_out_ready) begin
                  r_state     <= ST_IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready     = r_in_ready;
   assign o_out_valid    = r_out_valid;
   assign o_out_data     = r_out_data;
   assign o_out_count    = r_out_count;
   assign o_out_overflow = r_out_overflow;
   assign o_out_forced   = r_out_forced;

endmodule

// File: tb/tb_float_accumulator.sv
// Self-checking bench for float_accumulator (MAX_TERMS=4): directed table,
// hand-written handshake/reset sequences and randomized exact-sum packets.
module tb_float_accumulator;

   localparam int MT = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [31:0] i_in_data = 32'h0;
   logic        i_in_last = 1'b0;
   logic [31:0] i_bias = 32'h0;
   logic        o_out_valid;
   logic        i_out_ready = 1'b0;
   logic [31:0] o_out_data;
   logic [8:0]  o_out_count;
   logic        o_out_overflow;
   logic        o_out_forced;

   int n_vec = 0;
   int n_err = 0;

   float_accumulator #(.XLEN(32), .MAX_TERMS(MT), .CNT_W(9)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_data(i_in_data), .i_in_last(i_in_last), .i_bias(i_bias),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_out_count(o_out_count), .o_out_overflow(o_out_overflow), .o_out_forced(o_out_forced)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] bias;
      logic [31:0] beats [4];
      int          nb;
      logic        last;
      logic [31:0] e_data;
      int          e_cnt;
      logic        e_ovf;
      logic        e_forced;
   } vec_t;

   vec_t tbl [10];

   function automatic vec_t mk(input logic [31:0] bias, b0, b1, b2, b3, input int nb,
                               input logic last, input logic [31:0] e_data, input int e_cnt,
                               input logic e_ovf, input logic e_forced);
      vec_t v;
      v.bias = bias; v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
      v.nb = nb; v.last = last; v.e_data = e_data; v.e_cnt = e_cnt;
      v.e_ovf = e_ovf; v.e_forced = e_forced;
      return v;
   endfunction

   // Exact real -> single-precision encoding (inputs are chosen to be representable).
   function automatic logic [31:0] to_f(input real x);
      logic        s;
      int          e;
      real         m;
      int unsigned man;
      if (x == 0.0) return 32'h0;
      s = (x < 0.0);
      m = s ? -x : x;
      e = 127;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      man = int'((m - 1.0) * 8388608.0);
      return {s, e[7:0], man[22:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present a beat and wait (bounded) until the DUT accepts it; valid stays high.
   task automatic send_beat(input logic [31:0] bias, input logic [31:0] data, input logic last);
      logic accepted;
      logic rdy;
      accepted   = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = data;
      i_in_last  = last;
      i_bias     = bias;
      for (int t = 0; t < 20 && !accepted; t++) begin
         rdy = o_in_ready;
         tick();
         if (rdy) accepted = 1'b1;
      end
      if (!accepted) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_result(input string tag, input logic [31:0] e_data, input int e_cnt,
                               input logic e_ovf, input logic e_forced);
      check({tag, "_valid"}, 32'(o_out_valid), 32'd1);
      check({tag, "_data"}, o_out_data, e_data);
      check({tag, "_count"}, 32'(o_out_count), 32'(e_cnt));
      check({tag, "_ovf"}, 32'(o_out_overflow), 32'(e_ovf));
      check({tag, "_forced"}, 32'(o_out_forced), 32'(e_forced));
   endtask

   task automatic consume();
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      check("consume_valid_low", 32'(o_out_valid), 32'd0);
   endtask

   initial begin
      tbl[0] = mk(32'h0, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0, 3, 1'b1, 32'h40600000, 3, 1'b0, 1'b0);
      tbl[1] = mk(32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h00000000, 1, 1'b0, 1'b0);
      tbl[2] = mk(32'h0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4, 1'b0, 32'h40800000, 4, 1'b0, 1'b1);
      tbl[3] = mk(32'h0, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0, 2, 1'b1, 32'h7F800000, 2, 1'b1, 1'b0);
      tbl[4] = mk(32'hFF800000, 32'h7F800000, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h7F800000, 1, 1'b1, 1'b0);
      tbl[5] = mk(32'h40400000, 32'hC0000000, 32'hC0000000, 32'hC0000000, 32'h0, 3, 1'b1, 32'hC0400000, 3, 1'b0, 1'b0);
      tbl[6] = mk(32'h0, 32'h00000001, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h00000000, 1, 1'b0, 1'b0);
      tbl[7] = mk(32'h3F800000, 32'h33800000, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h3F800000, 1, 1'b0, 1'b0);
      tbl[8] = mk(32'h3F800000, 32'hB3000000, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h3F7FFFFF, 1, 1'b0, 1'b0);
      tbl[9] = mk(32'h7F000000, 32'h7F000000, 32'hFF000000, 32'h0, 32'h0, 2, 1'b1, 32'h7F800000, 2, 1'b1, 1'b0);

      tick();
      check("rst_in_ready", 32'(o_in_ready), 32'd1);
      check("rst_out_valid", 32'(o_out_valid), 32'd0);
      check("rst_out_data", o_out_data, 32'h0);
      check("rst_out_count", 32'(o_out_count), 32'd0);
      i_rst = 1'b0;
      tick();

      for (int v = 0; v < 10; v++) begin
         for (int b = 0; b < tbl[v].nb; b++)
            send_beat(tbl[v].bias, tbl[v].beats[b], tbl[v].last && (b == tbl[v].nb - 1));
         i_in_valid = 1'b0;
         check_result($sformatf("tbl%0d", v), tbl[v].e_data, tbl[v].e_cnt, tbl[v].e_ovf, tbl[v].e_forced);
         consume();
      end

      // Backpressure: result held, beat refused until the handshake.
      send_beat(32'h0, 32'h3F800000, 1'b0);
      send_beat(32'h0, 32'h40000000, 1'b1);
      i_in_data = 32'h40A00000; i_in_last = 1'b1; i_bias = 32'h3F800000; i_in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("bp_in_ready", 32'(o_in_ready), 32'd0);
         check("bp_data_hold", o_out_data, 32'h40400000);
         check("bp_valid_hold", 32'(o_out_valid), 32'd1);
         tick();
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      check("bp_idle_valid", 32'(o_out_valid), 32'd0);
      check("bp_idle_ready", 32'(o_in_ready), 32'd1);
      check("bp_idle_data", o_out_data, 32'h40400000);
      tick();
      i_in_valid = 1'b0;
      check_result("bp_next", 32'h40C00000, 1, 1'b0, 1'b0);
      consume();

      // Forced close: fifth beat waits and opens a new packet.
      for (int b = 0; b < 4; b++) send_beat(32'h0, 32'h3F800000, 1'b0);
      i_in_data = 32'h3F800000; i_in_last = 1'b1; i_bias = 32'h0; i_in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         check("forced_in_ready", 32'(o_in_ready), 32'd0);
         check_result("forced", 32'h40800000, 4, 1'b0, 1'b1);
         tick();
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      tick();
      i_in_valid = 1'b0;
      check_result("fifth", 32'h3F800000, 1, 1'b0, 1'b0);
      consume();

      // Reset mid-packet discards the partial sum.
      send_beat(32'h3F800000, 32'h40000000, 1'b0);
      send_beat(32'h0, 32'h40000000, 1'b0);
      i_in_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      check("mrst_valid", 32'(o_out_valid), 32'd0);
      check("mrst_ready", 32'(o_in_ready), 32'd1);
      check("mrst_data", o_out_data, 32'h0);
      check("mrst_count", 32'(o_out_count), 32'd0);
      tick();
      i_rst = 1'b0;
      send_beat(32'h40000000, 32'h40000000, 1'b1);
      i_in_valid = 1'b0;
      check_result("post_rst", 32'h40800000, 1, 1'b0, 1'b0);
      consume();

      // Random packets of exactly representable quarter-integers vs a real-arithmetic model.
      for (int p = 0; p < 150; p++) begin
         real         sum;
         real         x;
         int          nb;
         logic        last;
         logic [31:0] bias_f;
         nb   = int'($urandom_range(1, MT));
         last = (nb < MT) ? 1'b1 : 1'($urandom_range(0, 1));
         x    = real'(int'($urandom_range(0, 4000)) - 2000) / 4.0;
         sum  = x;
         bias_f = to_f(x);
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               i_in_valid = 1'b0;
               tick();
            end
            x   = real'(int'($urandom_range(0, 4000)) - 2000) / 4.0;
            sum = sum + x;
            send_beat(bias_f, to_f(x), last && (b == nb - 1));
         end
         i_in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         check_result($sformatf("rnd%0d", p), to_f(sum), nb, 1'b0, !last);
         consume();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
